// File: rtl/int_fsm_if.sv
// Interrupt-entry sequencer bus: request/interlock inputs and the injected
// instruction stream with its fetch-control strobes.
interface int_fsm_if;
  logic        intr;
  logic        rti_busy;
  logic [15:0] out;
  logic        stall;
  logic        vec_load;
  logic        busy;

  modport master (output intr, rti_busy, input out, stall, vec_load, busy);
  modport slave  (input intr, rti_busy, output out, stall, vec_load, busy);
endinterface

// File: rtl/int_fsm.sv
// Interrupt-entry sequencer: injects PUSH CCR / PC_LOW / PC_HIGH, pulses vector load,
// then drains with NOPs. Define INT_PENDING_LATCH_EN to hold one deferred request.
module int_fsm #(
  parameter logic [15:0] PUSH_CCR_OP     = 16'hFFFE,
  parameter logic [15:0] PUSH_PC_LOW_OP  = 16'b0101000010001000,
  parameter logic [15:0] PUSH_PC_HIGH_OP = 16'b0101000010001001,
  parameter int unsigned NOP_CYCLES      = 4
) (
  input  logic     clk,
  input  logic     reset,
  int_fsm_if.slave bus
);

`ifdef INT_PENDING_LATCH_EN
  localparam bit LATCH_EN = 1'b1;
`else
  localparam bit LATCH_EN = 1'b0;
`endif

  localparam logic [3:0] NOP_LOAD = 4'(NOP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH_CCR, S_PUSH_PC_LOW, S_PUSH_PC_HIGH, S_VEC, S_NOP
  } state_e;

  state_e      state_q, state_d;
  logic        intr_q, intr_qq;
  logic [3:0]  nop_cnt_q, nop_cnt_d;
  logic        pending_q, pending_d;
  logic [15:0] out_q, out_d;
  logic        stall_q, stall_d;
  logic        vec_q, vec_d;
  logic        req;

  // intr is registered before edge detection, so an edge captured at clock N
  // starts the sequence at clock N+1.
  assign req = intr_q & ~intr_qq;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      intr_q    <= 1'b0;
      intr_qq   <= 1'b0;
      nop_cnt_q <= '0;
      pending_q <= 1'b0;
      out_q     <= '0;
      stall_q   <= 1'b0;
      vec_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      intr_q    <= bus.intr;
      intr_qq   <= intr_q;
      nop_cnt_q <= nop_cnt_d;
      pending_q <= pending_d;
      out_q     <= out_d;
      stall_q   <= stall_d;
      vec_q     <= vec_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    nop_cnt_d = nop_cnt_q;
    // Any request not consumed below is remembered (merged with an existing one).
    pending_d = LATCH_EN & (pending_q | req);
    case (state_q)
      S_IDLE: begin
        if ((req | pending_q) & ~bus.rti_busy) begin
          state_d   = S_PUSH_CCR;
          pending_d = 1'b0;
        end
      end
      S_PUSH_CCR:     state_d = S_PUSH_PC_LOW;
      S_PUSH_PC_LOW:  state_d = S_PUSH_PC_HIGH;
      S_PUSH_PC_HIGH: state_d = S_VEC;
      S_VEC: begin
        state_d   = S_NOP;
        nop_cnt_d = NOP_LOAD;
      end
      S_NOP: begin
        if (nop_cnt_q == 4'd0) begin
          if (LATCH_EN & (req | pending_q)) begin
            state_d   = S_PUSH_CCR;
            pending_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          nop_cnt_d = nop_cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs decode the upcoming state so they appear on the edge that enters it.
    out_d = 16'h0000;
    case (state_d)
      S_PUSH_CCR:     out_d = PUSH_CCR_OP;
      S_PUSH_PC_LOW:  out_d = PUSH_PC_LOW_OP;
      S_PUSH_PC_HIGH: out_d = PUSH_PC_HIGH_OP;
      default:        out_d = 16'h0000;
    endcase
    stall_d = (state_d != S_IDLE);
    vec_d   = (state_d == S_VEC);
  end

  assign bus.out      = out_q;
  assign bus.stall    = stall_q;
  assign bus.busy     = stall_q;
  assign bus.vec_load = vec_q;

endmodule

// File: tb/tb_int_fsm.sv
// Bench for int_fsm: two instances (NOP_CYCLES=4 and 1) on shared stimulus, checked
// each cycle against a frame-position model plus directed literal expectations.
module tb_int_fsm;

`ifdef INT_PENDING_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int_fsm_if bus0 ();
  int_fsm_if bus1 ();

  int_fsm #(.NOP_CYCLES(4)) u0 (.clk(clk), .reset(reset), .bus(bus0));
  int_fsm #(.NOP_CYCLES(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
    end
  endtask

  // Stimulus drives both instances identically.
  logic intr = 1'b0;
  logic rti  = 1'b0;
  assign bus0.intr = intr;
  assign bus1.intr = intr;
  assign bus0.rti_busy = rti;
  assign bus1.rti_busy = rti;

  // Model: k = position in the injected frame (-1 idle). Frame length is 4+NOP.
  int nopc [2] = '{4, 1};
  int k [2];
  bit pend [2];
  bit i1, i2;

  always @(posedge clk) begin
    bit req, last;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin k[i] = -1; pend[i] = 0; end
      i1 = 0; i2 = 0;
    end else begin
      req = i1 & ~i2;
      for (int i = 0; i < 2; i++) begin
        last = (k[i] == 3 + nopc[i]);
        if (k[i] < 0) begin
          if ((req | pend[i]) && !rti) begin k[i] = 0; pend[i] = 0; end
          else if (req && LATCH) pend[i] = 1;
        end else if (last) begin
          if (LATCH && (req | pend[i])) begin k[i] = 0; pend[i] = 0; end
          else k[i] = -1;
        end else begin
          k[i]++;
          if (req && LATCH) pend[i] = 1;
        end
      end
      i2 = i1;
      i1 = intr;
    end
  end

  function automatic logic [15:0] exp_word(input int kk);
    case (kk)
      0: return 16'hFFFE;
      1: return 16'h5088;
      2: return 16'h5089;
      default: return 16'h0000;
    endcase
  endfunction

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("u0_out",   bus0.out,             exp_word(k[0]));
      check("u0_stall", {15'd0, bus0.stall},    {15'd0, k[0] >= 0});
      check("u0_busy",  {15'd0, bus0.busy},     {15'd0, k[0] >= 0});
      check("u0_vec",   {15'd0, bus0.vec_load}, {15'd0, k[0] == 3});
      check("u1_out",   bus1.out,             exp_word(k[1]));
      check("u1_stall", {15'd0, bus1.stall},    {15'd0, k[1] >= 0});
      check("u1_busy",  {15'd0, bus1.busy},     {15'd0, k[1] >= 0});
      check("u1_vec",   {15'd0, bus1.vec_load}, {15'd0, k[1] == 3});
    end
  end

  int sc0 = 0, sc1 = 0, vc0 = 0;
  always @(negedge clk) begin
    if (bus0.stall === 1'b1) sc0++;
    if (bus1.stall === 1'b1) sc1++;
    if (bus0.vec_load === 1'b1) vc0++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    intr = 1'b1;
    cyc(1);
    intr = 1'b0;
  endtask

  logic [15:0] t1_out   [9] = '{16'hFFFE, 16'h5088, 16'h5089, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
  logic        t1_stall [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic        t1_vec   [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    cyc(3);
    chk_en = 1;
    check("rst_out", bus0.out, 16'h0000);
    check("rst_stall", {15'd0, bus0.stall}, 16'd0);
    reset = 1'b1;
    cyc(3);

    // 1: single pulse, exact per-edge frame
    sc0 = 0; sc1 = 0; vc0 = 0;
    pulse();
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      check("t1_out", bus0.out, t1_out[i]);
      check("t1_stall", {15'd0, bus0.stall}, {15'd0, t1_stall[i]});
      check("t1_vec", {15'd0, bus0.vec_load}, {15'd0, t1_vec[i]});
    end
    cyc(5);
    check("t6_u1_stall_cycles", 16'(sc1), 16'd5);

    // 2: held-high intr gives one sequence
    sc0 = 0; vc0 = 0;
    intr = 1'b1;
    cyc(20);
    intr = 1'b0;
    cyc(15);
    check("t2_stall_cycles", 16'(sc0), 16'd8);
    check("t2_vec_pulses", 16'(vc0), 16'd1);

    // 3: request under rti_busy
    sc0 = 0;
    rti = 1'b1;
    pulse();
    cyc(5);
    rti = 1'b0;
    cyc(1);
    check("t3_first_after_rti", bus0.out, LATCH ? 16'hFFFE : 16'h0000);
    cyc(15);
    check("t3_stall_cycles", 16'(sc0), LATCH ? 16'd8 : 16'd0);

    // 4: reset during PUSH_PC_HIGH, then a fresh sequence
    pulse();
    cyc(3);
    check("t4_pc_high", bus0.out, 16'h5089);
    reset = 1'b0;
    cyc(1);
    check("t4_rst_out", bus0.out, 16'h0000);
    check("t4_rst_stall", {15'd0, bus0.stall}, 16'd0);
    check("t4_rst_busy", {15'd0, bus0.busy}, 16'd0);
    check("t4_rst_vec", {15'd0, bus0.vec_load}, 16'd0);
    reset = 1'b1;
    cyc(3);
    sc0 = 0;
    pulse();
    cyc(15);
    check("t4_restart_stall_cycles", 16'(sc0), 16'd8);

    // 5: second edge during NOP drain
    sc0 = 0;
    pulse();
    cyc(5);
    pulse();
    cyc(25);
    check("t5_stall_cycles", 16'(sc0), LATCH ? 16'd16 : 16'd8);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) intr = ~intr;
      if ($urandom_range(0, 7) == 0) rti = ~rti;
      cyc(1);
    end
    intr = 1'b0;
    rti = 1'b0;
    cyc(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
